// File: rtl/frame_scaler_pkg.sv
// rtl/frame_scaler_pkg.sv - scale modes, factor lookup and border colour for frame_scaler
package frame_scaler_pkg;

  typedef enum logic [1:0] {SCALE_X1, SCALE_X2, SCALE_X3, SCALE_X4} scale_mode_t;

  localparam logic [15:0] BORDER_COLOR = 16'hFFFF;

  function automatic logic [2:0] scale_factor(scale_mode_t mode);
    case (mode)
      SCALE_X2: return 3'd2;
      SCALE_X3: return 3'd3;
      SCALE_X4: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

  function automatic int clip(int a, int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_scaler_delay_pipe.sv
// rtl/frame_scaler_delay_pipe.sv - scale_delay_pipe: fixed-depth shift register, sync reset to 0
module scale_delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = data_in;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_scaler.sv
// rtl/frame_scaler.sv - nearest-neighbour integer upscaler (x1..x4) from frame buffer to 720p raster
// Optional white border on the scaled window when FRAME_SCALER_BORDER_EN is defined.
module frame_scaler
  import frame_scaler_pkg::*;
#(
  parameter int SRC_W    = 320,
  parameter int SRC_H    = 240,
  parameter int ACTIVE_H = 1280,
  parameter int ACTIVE_V = 720,
  parameter int READ_LAT = 2,
  parameter int PIX_W    = 16,
  parameter int ADDR_W   = $clog2(SRC_W * SRC_H)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        scale_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  output logic [ADDR_W-1:0] addr_out,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic [PIX_W-1:0]  pixel_out,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic              in_window_out,
  output logic              sync_err_out
);

  localparam int LAT   = READ_LAT + 2;
  // row_base keeps stepping past the window on every line, so size it for any vcount
  localparam int ROW_W = $clog2(SRC_W) + 10;
  localparam int WIN_W1 = clip(SRC_W * 1, ACTIVE_H);
  localparam int WIN_W2 = clip(SRC_W * 2, ACTIVE_H);
  localparam int WIN_W3 = clip(SRC_W * 3, ACTIVE_H);
  localparam int WIN_W4 = clip(SRC_W * 4, ACTIVE_H);
  localparam int WIN_H1 = clip(SRC_H * 1, ACTIVE_V);
  localparam int WIN_H2 = clip(SRC_H * 2, ACTIVE_V);
  localparam int WIN_H3 = clip(SRC_H * 3, ACTIVE_V);
  localparam int WIN_H4 = clip(SRC_H * 4, ACTIVE_V);

  scale_mode_t       mode_q, mode_d;
  logic [10:0]       prev_h_q, prev_h_d;
  logic              synced_q, synced_d;
  logic              line_bad_q, line_bad_d;
  logic              err_q, err_d;
  logic [1:0]        x_phase_q, x_phase_d;
  logic [10:0]       src_x_q, src_x_d;
  logic [1:0]        y_phase_q, y_phase_d;
  logic [ROW_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [10:0]       hout_q;
  logic [9:0]        vout_q;
  logic              win_out_q;

  logic        frame_start, line_start, jump, win;
  logic [2:0]  k;
  logic [1:0]  k_last;
  logic [10:0] win_w;
  logic [9:0]  win_h;
  logic [21:0] bundle_dly;
  logic [10:0] dly_h;
  logic [9:0]  dly_v;
  logic        dly_win;

  always_comb begin
    frame_start = (hcount_in == '0) && (vcount_in == '0);
    line_start  = (hcount_in == '0);
    mode_d      = frame_start ? scale_mode_t'(scale_in) : mode_q;
    k           = scale_factor(mode_d);
    k_last      = 2'(k - 3'd1);

    jump       = synced_q && !line_start && (hcount_in != prev_h_q + 11'd1);
    prev_h_d   = hcount_in;
    synced_d   = synced_q | line_start;
    line_bad_d = line_start ? 1'b0 : (line_bad_q | jump);
    err_d      = err_q | jump;

    // Counters describe the current input position; the _q copies hold the previous one.
    if (line_start) begin
      x_phase_d = '0;
      src_x_d   = '0;
    end else if (x_phase_q == k_last) begin
      x_phase_d = '0;
      src_x_d   = src_x_q + 11'd1;
    end else begin
      x_phase_d = x_phase_q + 2'd1;
      src_x_d   = src_x_q;
    end

    y_phase_d  = y_phase_q;
    row_base_d = row_base_q;
    if (frame_start) begin
      y_phase_d  = '0;
      row_base_d = '0;
    end else if (line_start) begin
      if (y_phase_q == k_last) begin
        y_phase_d  = '0;
        row_base_d = row_base_q + ROW_W'(SRC_W);
      end else begin
        y_phase_d  = y_phase_q + 2'd1;
      end
    end

    case (mode_d)
      SCALE_X2: begin win_w = 11'(WIN_W2); win_h = 10'(WIN_H2); end
      SCALE_X3: begin win_w = 11'(WIN_W3); win_h = 10'(WIN_H3); end
      SCALE_X4: begin win_w = 11'(WIN_W4); win_h = 10'(WIN_H4); end
      default:  begin win_w = 11'(WIN_W1); win_h = 10'(WIN_H1); end
    endcase

    win    = synced_d && !line_bad_d && (hcount_in < win_w) && (vcount_in < win_h);
    addr_d = win ? ADDR_W'(row_base_d + ROW_W'(src_x_d)) : addr_q;
  end

  scale_delay_pipe #(.WIDTH(22), .DEPTH(LAT - 1)) u_pos_dly (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  ({hcount_in, vcount_in, win}),
    .data_out (bundle_dly)
  );

  assign dly_h   = bundle_dly[21:11];
  assign dly_v   = bundle_dly[10:1];
  assign dly_win = bundle_dly[0];

`ifdef FRAME_SCALER_BORDER_EN
  logic border, dly_border;

  always_comb begin
    border = (hcount_in == '0) || (hcount_in == win_w - 11'd1) ||
             (vcount_in == '0) || (vcount_in == win_h - 10'd1);
  end

  scale_delay_pipe #(.WIDTH(1), .DEPTH(LAT - 1)) u_brd_dly (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (border),
    .data_out (dly_border)
  );

  always_comb begin
    pix_d = '0;
    if (dly_win) pix_d = dly_border ? PIX_W'(BORDER_COLOR) : pixel_in;
  end
`else
  always_comb begin
    pix_d = '0;
    if (dly_win) pix_d = pixel_in;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_q     <= SCALE_X1;
      prev_h_q   <= '0;
      synced_q   <= 1'b0;
      line_bad_q <= 1'b0;
      err_q      <= 1'b0;
      x_phase_q  <= '0;
      src_x_q    <= '0;
      y_phase_q  <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      pix_q      <= '0;
      hout_q     <= '0;
      vout_q     <= '0;
      win_out_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      prev_h_q   <= prev_h_d;
      synced_q   <= synced_d;
      line_bad_q <= line_bad_d;
      err_q      <= err_d;
      x_phase_q  <= x_phase_d;
      src_x_q    <= src_x_d;
      y_phase_q  <= y_phase_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      pix_q      <= pix_d;
      hout_q     <= dly_h;
      vout_q     <= dly_v;
      win_out_q  <= dly_win;
    end
  end

  assign addr_out      = addr_q;
  assign pixel_out     = pix_q;
  assign hcount_out    = hout_q;
  assign vcount_out    = vout_q;
  assign in_window_out = win_out_q;
  assign sync_err_out  = err_q;

endmodule

// File: tb/tb_frame_scaler.sv
// tb/tb_frame_scaler.sv - directed bench for frame_scaler with a 2-cycle frame-buffer model
module tb_frame_scaler;

  localparam int ADDR_W = 17;
  localparam int LAT    = 4;
`ifdef FRAME_SCALER_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        scale;
  logic [10:0]       h_in;
  logic [9:0]        v_in;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       pix_in;
  logic [15:0]       pix_out;
  logic [10:0]       h_out;
  logic [9:0]        v_out;
  logic              win_out;
  logic              err_out;
  logic [ADDR_W-1:0] rd_addr_q;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;

  typedef struct { string tag; int h; int v; bit win; int addr; bit brd; } probe_t;
  typedef struct { int due; string tag; int h; int v; bit win; logic [15:0] pix; } pend_t;
  probe_t probes[$];
  pend_t  pend[$];

  always #5 clk = ~clk;

  frame_scaler dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .scale_in      (scale),
    .hcount_in     (h_in),
    .vcount_in     (v_in),
    .addr_out      (addr),
    .pixel_in      (pix_in),
    .pixel_out     (pix_out),
    .hcount_out    (h_out),
    .vcount_out    (v_out),
    .in_window_out (win_out),
    .sync_err_out  (err_out)
  );

  function automatic logic [15:0] mem(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  always @(posedge clk) begin
    rd_addr_q <= addr;
    pix_in    <= mem(rd_addr_q);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_probe(input string tag, input int h, input int v, input bit win,
                           input int a, input bit brd);
    probe_t p;
    p.tag = tag; p.h = h; p.v = v; p.win = win; p.addr = a; p.brd = brd;
    probes.push_back(p);
  endtask

  task automatic drive(input int h, input int v);
    h_in = 11'(h);
    v_in = 10'(v);
    @(posedge clk);
    #1;
    ncyc++;
    for (int i = 0; i < probes.size(); i++) begin
      if (probes[i].h == h && probes[i].v == v) begin
        probe_t p;
        pend_t  q;
        p = probes[i];
        if (p.win) check_eq({p.tag, ".addr"}, 32'(addr), 32'(p.addr));
        q.due = ncyc + LAT - 1;
        q.tag = p.tag; q.h = h; q.v = v; q.win = p.win;
        q.pix = !p.win ? 16'h0 : (BORDER && p.brd) ? 16'hFFFF : mem(ADDR_W'(p.addr));
        pend.push_back(q);
        probes.delete(i);
        break;
      end
    end
    while (pend.size() > 0 && pend[0].due == ncyc) begin
      pend_t q;
      q = pend.pop_front();
      check_eq({q.tag, ".win"}, 32'(win_out), 32'(q.win));
      check_eq({q.tag, ".pix"}, 32'(pix_out), 32'(q.pix));
      check_eq({q.tag, ".hout"}, 32'(h_out), 32'(q.h));
      check_eq({q.tag, ".vout"}, 32'(v_out), 32'(q.v));
    end
  endtask

  task automatic run_line(input int v, input int hmax);
    for (int h = 0; h <= hmax; h++) drive(h, v);
  endtask

  task automatic end_frame(input string tag);
    check_eq({tag, ".probes_left"}, 32'(probes.size()), 32'd0);
    probes.delete();
  endtask

  initial begin
    rst = 1'b1; scale = 2'b00; h_in = '0; v_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.addr", 32'(addr), 0);
    check_eq("rst.pix", 32'(pix_out), 0);
    check_eq("rst.hout", 32'(h_out), 0);
    check_eq("rst.vout", 32'(v_out), 0);
    check_eq("rst.win", 32'(win_out), 0);
    check_eq("rst.err", 32'(err_out), 0);
    rst = 1'b0;

    // x1 frame
    scale = 2'b00;
    add_probe("x1_h5v2", 5, 2, 1, 645, 0);
    add_probe("x1_h319", 319, 0, 1, 319, 1);
    add_probe("x1_h320", 320, 0, 0, 0, 0);
    add_probe("x1_last", 319, 239, 1, 76799, 1);
    add_probe("x1_v240", 0, 240, 0, 0, 0);
    for (int v = 0; v <= 240; v++)
      run_line(v, (v == 0 || v == 239) ? 325 : (v == 2) ? 8 : 3);
    end_frame("x1");

    // x2 frame
    scale = 2'b01;
    add_probe("x2_h7v5", 7, 5, 1, 643, 0);
    add_probe("x2_h639", 639, 0, 1, 319, 1);
    add_probe("x2_h640", 640, 0, 0, 0, 0);
    add_probe("x2_v479", 0, 479, 1, 76480, 1);
    add_probe("x2_v480", 0, 480, 0, 0, 0);
    for (int v = 0; v <= 480; v++)
      run_line(v, (v == 0) ? 645 : (v == 5) ? 10 : 3);
    end_frame("x2");

    // x4 frame, clipped at 720 lines
    scale = 2'b11;
    add_probe("x4_h7v9", 7, 9, 1, 641, 0);
    add_probe("x4_h1280", 1280, 0, 0, 0, 0);
    add_probe("x4_corner", 1279, 719, 1, 57599, 1);
    add_probe("x4_v720a", 0, 720, 0, 0, 0);
    add_probe("x4_v720b", 100, 720, 0, 0, 0);
    for (int v = 0; v <= 721; v++)
      run_line(v, (v == 0) ? 1283 : (v == 719) ? 1285 : (v == 720) ? 105 : (v == 9) ? 10 : 3);
    end_frame("x4");

    // mode request changes mid-frame: x1 holds, x3 takes over next frame
    scale = 2'b00;
    add_probe("mc_h5v200", 5, 200, 1, 64005, 0);
    add_probe("mc_v240", 0, 240, 0, 0, 0);
    add_probe("mc_v749", 0, 749, 0, 0, 0);
    for (int v = 0; v <= 749; v++) begin
      if (v == 100) scale = 2'b10;
      run_line(v, (v == 200) ? 10 : 3);
    end
    end_frame("mc1");
    add_probe("x3_h4v4", 4, 4, 1, 321, 0);
    add_probe("x3_h959", 959, 0, 1, 319, 1);
    add_probe("x3_h960", 960, 0, 0, 0, 0);
    add_probe("x3_v719", 7, 719, 1, 76482, 1);
    add_probe("x3_v720", 0, 720, 0, 0, 0);
    for (int v = 0; v <= 720; v++)
      run_line(v, (v == 0) ? 965 : (v == 719 || v == 4) ? 10 : 3);
    end_frame("x3");

    // border positions in x1 (raw pixels when the border build is off)
    scale = 2'b00;
    add_probe("brd_0_0", 0, 0, 1, 0, 1);
    add_probe("brd_319_10", 319, 10, 1, 3519, 1);
    add_probe("brd_10_239", 10, 239, 1, 76490, 1);
    add_probe("brd_1_1", 1, 1, 1, 321, 0);
    for (int v = 0; v <= 240; v++)
      run_line(v, (v == 10 || v == 239) ? 325 : 3);
    end_frame("brd");

    // hcount jump 40 -> 45 on line 3
    scale = 2'b00;
    add_probe("sy_h40", 40, 3, 1, 1000, 0);
    add_probe("sy_h45", 45, 3, 0, 0, 0);
    add_probe("sy_h60", 60, 3, 0, 0, 0);
    add_probe("sy_next", 5, 4, 1, 1285, 0);
    for (int v = 0; v <= 5; v++) begin
      if (v == 3) begin
        check_eq("sy.err_before", 32'(err_out), 0);
        for (int h = 0; h <= 40; h++) drive(h, v);
        for (int h = 45; h <= 60; h++) drive(h, v);
        check_eq("sy.err_set", 32'(err_out), 1);
      end else begin
        run_line(v, 8);
      end
    end
    for (int h = 0; h <= 5; h++) drive(h, 0);
    check_eq("sy.err_sticky", 32'(err_out), 1);
    end_frame("sy");
    check_eq("pending_left", 32'(pend.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
